pcs_tx_gearbox_ctrl: RTL
========================

// Module: pcs_tx_gearbox_ctrl
// PURPOSE
//  Sequencer for the 64b/66b TX path: 32-bit MAC words feed the 64b/66b encoder, whose blocks go to a GT async gearbox.
//  Brings the path up once the GT is ready and drives o_init_done to the encoder's i_init_done.
//  Generates the half-word phase, the GT tx sequence count and the header-valid strobe.
//  Pauses the MAC for one 64-bit block in every 33 so 32 x 66-bit blocks fit 66 x 32-bit gearbox slots.
// PARAMETERS
//  SEQ_W       6   width of o_gt_txsequence
//  PAUSE_SEQ   32  sequence value on which the gearbox slips; period = 2*(PAUSE_SEQ+1) cycles
//  READY_HOLD  16  consecutive cycles i_gt_tx_ready && i_enable must be high before RUN (>=1)
// PORTS
//  i_txc             in   1      TX word clock; sole clock
//  i_reset           in   1      reset, asynchronous, active-high
//  i_gt_tx_ready     in   1      GT TX reset-done / ready (already synchronous to i_txc)
//  i_enable          in   1      software enable of TX datapath
//  o_init_done       out  1      to encoder i_init_done; high only in RUN and DRAIN
//  o_phase           out  1      0 = lower word of block (txd[31:0]), 1 = upper word
//  o_tx_pause        out  1      MAC must hold its word this cycle
//  o_tx_pause_next   out  1      value o_tx_pause takes next cycle (for pipelined MAC)
//  o_gt_txsequence   out  SEQ_W  gearbox sequence count
//  o_header_valid    out  1      66-bit block complete (phase 1, not paused)
//  o_state           out  2      FSM state, debug
// BEHAVIOUR
//  Clock/reset: one clock i_txc. Reset i_reset is asynchronous, active-high. All outputs are registered.
//  Reset values: state=WAIT_READY, o_init_done=0, o_phase=0, o_tx_pause=1, o_tx_pause_next=1, o_gt_txsequence=0, o_header_valid=0, hold count=0.
//  WAIT_READY:
//   - Hold counter increments while i_gt_tx_ready && i_enable; it clears on any low cycle.
//   - Cycle where count==READY_HOLD-1 and inputs are high: next state RUN; o_tx_pause_next=0 in that cycle.
//   - o_init_done=0, o_phase=0, o_gt_txsequence=0, o_tx_pause=1.
//   - First RUN cycle is READY_HOLD cycles after ready&&enable are first sampled high.
//  RUN:
//   - o_init_done=1. o_phase toggles every cycle; first RUN cycle has phase 0, sequence 0.
//   - o_gt_txsequence increments after each phase-1 cycle.
//   - After the phase-1 cycle of PAUSE_SEQ, o_gt_txsequence wraps to 0.
//   - o_tx_pause=1 on both cycles where o_gt_txsequence==PAUSE_SEQ; o_header_valid=0 on those cycles.
//   - o_header_valid=1 on every other phase-1 cycle.
//   - o_tx_pause_next=1 when (seq==PAUSE_SEQ-1 && phase==1) or (seq==PAUSE_SEQ && phase==0).
//  DRAIN (i_enable low in RUN):
//   - Entered from RUN when i_enable is sampled low with phase 0; the current block completes.
//   - In DRAIN, phase/seq/header_valid advance as in RUN for that one cycle; exit to WAIT_READY after the phase-1 cycle.
//   - If i_enable is sampled low on a phase-1 cycle: go straight to WAIT_READY (block already complete).
//   - o_tx_pause_next=1 throughout DRAIN.
//  GT ready loss: i_gt_tx_ready low in RUN or DRAIN aborts at once.
//   - Next cycle is WAIT_READY with reset values; hold counter=0. Ready loss has priority over enable loss.
//  Pause window: enable loss during the pause window goes directly to WAIT_READY. No block is in flight.
//  Async reset mid-operation forces reset values immediately; no partial block is flagged valid.
// STRUCTURE
//  Shared package (encoder_pkg):
//   - typedef enum logic[1:0] {GB_WAIT_READY=0, GB_RUN=1, GB_DRAIN=2} gb_state_t
//   - localparam GB_PAUSE_SEQ_DEFAULT=32
//  Sub-module ready_filter:
//   - Parameterised consecutive-high counter.
//   - Output: stable pulse when the count reaches READY_HOLD-1.
//  FSM, phase and sequence logic live in the top module.
// TESTING
//  1 Bring-up:
//   - Stimulus: reset, then ready=enable=1 from cycle 0, READY_HOLD=16.
//   - Response: o_init_done rises at cycle 16 with phase 0, seq 0, pause 0.
//   - Response: o_tx_pause_next=0 at cycle 15.
//  2 Steady state, over 132 cycles:
//   - Exactly 4 pause cycles, in 2 adjacent pairs at seq 32.
//   - Exactly 64 header_valid pulses.
//   - Sequence runs 0..32, then wraps to 0.
//  3 Filter glitch: ready drops for 1 cycle at hold count 10 -> counter restarts; RUN starts 16 cycles after re-rise.
//  4 Enable drop in RUN:
//   - Drop at phase 0, seq 5 -> 1 DRAIN cycle, header_valid at seq 5, then WAIT_READY.
//   - Drop at phase 1 -> WAIT_READY next cycle.
//  5 GT loss: ready and enable drop together at seq 32, phase 0 -> next cycle WAIT_READY, init_done=0, seq=0, pause=1.
//  6 Async reset: assert mid-cycle at seq 20 -> outputs reach reset values before the next i_txc edge; re-bring-up matches test 1.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and defaults for the 64b/66b TX path sequencing logic.
package encoder_pkg;

  typedef enum logic [1:0] {
    GB_WAIT_READY = 2'd0,
    GB_RUN        = 2'd1,
    GB_DRAIN      = 2'd2
  } gb_state_t;

  localparam int GB_PAUSE_SEQ_DEFAULT  = 32;
  localparam int GB_SEQ_W_DEFAULT      = 6;
  localparam int GB_READY_HOLD_DEFAULT = 16;

  // True in the states where the encoder is fed and blocks are emitted.
  function automatic logic gb_is_active(input gb_state_t s);
    return (s == GB_RUN) || (s == GB_DRAIN);
  endfunction

endpackage

// File: rtl/pcs_tx_gearbox_ctrl_ready_filter.sv
// Consecutive-high qualifier: flags the cycle in which the level has been
// high for HOLD samples in a row, plus a look-ahead for the following cycle.
module ready_filter #(
  parameter int HOLD = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  input  logic i_clear,
  output logic o_hit,
  output logic o_armed_next
);

  localparam int              CW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0]   LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  // Next count: restart on any low sample, on clear, or once the hold is met.
  always_comb begin
    w_count_next = '0;
    if (i_clear || !i_level) begin
      w_count_next = '0;
    end else if (r_count == LAST) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + ONE;
    end
  end

  // Hold counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_hit        = i_level && !i_clear && (r_count == LAST);
  assign o_armed_next = (w_count_next == LAST);

endmodule

// File: rtl/pcs_tx_gearbox_ctrl.sv
// TX gearbox sequencer: bring-up FSM, half-word phase, GT sequence count,
// MAC pause and header-valid strobes for a 64b/66b async gearbox.
module pcs_tx_gearbox_ctrl
  import encoder_pkg::*;
#(
  parameter int SEQ_W      = GB_SEQ_W_DEFAULT,
  parameter int PAUSE_SEQ  = GB_PAUSE_SEQ_DEFAULT,
  parameter int READY_HOLD = GB_READY_HOLD_DEFAULT
) (
  input  logic             i_txc,
  input  logic             i_reset,
  input  logic             i_gt_tx_ready,
  input  logic             i_enable,
  output logic             o_init_done,
  output logic             o_phase,
  output logic             o_tx_pause,
  output logic             o_tx_pause_next,
  output logic [SEQ_W-1:0] o_gt_txsequence,
  output logic             o_header_valid,
  output logic [1:0]       o_state
);

  localparam logic [SEQ_W-1:0] SEQ_PAUSE = SEQ_W'(PAUSE_SEQ);
  localparam logic [SEQ_W-1:0] SEQ_PRE   = SEQ_W'(PAUSE_SEQ - 1);
  localparam logic [SEQ_W-1:0] SEQ_ONE   = SEQ_W'(1);

  gb_state_t        r_state;
  logic             r_phase;
  logic [SEQ_W-1:0] r_seq;
  logic             r_init_done;
  logic             r_pause;
  logic             r_pause_next;
  logic             r_header_valid;

  gb_state_t        w_state_next;
  logic             w_phase_next;
  logic [SEQ_W-1:0] w_seq_next;
  logic [SEQ_W-1:0] w_seq_adv;
  logic             w_level;
  logic             w_clear;
  logic             w_hit;
  logic             w_armed_next;
  logic             w_init_done_d;
  logic             w_pause_d;
  logic             w_pause_next_d;
  logic             w_header_valid_d;

  assign w_level = i_gt_tx_ready && i_enable;
  assign w_clear = (r_state != GB_WAIT_READY);

  ready_filter #(
    .HOLD (READY_HOLD)
  ) u_ready_filter (
    .i_clk        (i_txc),
    .i_rst        (i_reset),
    .i_level      (w_level),
    .i_clear      (w_clear),
    .o_hit        (w_hit),
    .o_armed_next (w_armed_next)
  );

  // Next state, phase and sequence; ready loss outranks enable loss.
  always_comb begin
    w_state_next = r_state;
    w_phase_next = 1'b0;
    w_seq_next   = '0;
    if (r_phase) begin
      w_seq_adv = (r_seq == SEQ_PAUSE) ? '0 : (r_seq + SEQ_ONE);
    end else begin
      w_seq_adv = r_seq;
    end
    case (r_state)
      GB_WAIT_READY: begin
        if (w_hit) begin
          w_state_next = GB_RUN;
        end else begin
          w_state_next = GB_WAIT_READY;
        end
      end
      GB_RUN: begin
        if (!i_gt_tx_ready) begin
          w_state_next = GB_WAIT_READY;
        end else if (!i_enable) begin
          // Only a lower half-word outside the pause slot leaves a block to finish.
          if (!r_phase && (r_seq != SEQ_PAUSE)) begin
            w_state_next = GB_DRAIN;
            w_phase_next = 1'b1;
            w_seq_next   = r_seq;
          end else begin
            w_state_next = GB_WAIT_READY;
          end
        end else begin
          w_state_next = GB_RUN;
          w_phase_next = ~r_phase;
          w_seq_next   = w_seq_adv;
        end
      end
      GB_DRAIN: begin
        w_state_next = GB_WAIT_READY;
      end
      default: begin
        w_state_next = GB_WAIT_READY;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    w_init_done_d    = gb_is_active(w_state_next);
    w_pause_d        = 1'b1;
    w_pause_next_d   = 1'b1;
    w_header_valid_d = 1'b0;
    case (w_state_next)
      GB_WAIT_READY: begin
        w_pause_d        = 1'b1;
        w_pause_next_d   = !w_armed_next;
        w_header_valid_d = 1'b0;
      end
      GB_RUN: begin
        w_pause_d        = (w_seq_next == SEQ_PAUSE);
        w_pause_next_d   = ((w_seq_next == SEQ_PRE) && w_phase_next) ||
                           ((w_seq_next == SEQ_PAUSE) && !w_phase_next);
        w_header_valid_d = w_phase_next && (w_seq_next != SEQ_PAUSE);
      end
      GB_DRAIN: begin
        w_pause_d        = (w_seq_next == SEQ_PAUSE);
        w_pause_next_d   = 1'b1;
        w_header_valid_d = w_phase_next && (w_seq_next != SEQ_PAUSE);
      end
      default: begin
        w_pause_d        = 1'b1;
        w_pause_next_d   = 1'b1;
        w_header_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_txc or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= GB_WAIT_READY;
      r_phase        <= 1'b0;
      r_seq          <= '0;
      r_init_done    <= 1'b0;
      r_pause        <= 1'b1;
      r_pause_next   <= 1'b1;
      r_header_valid <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_phase        <= w_phase_next;
      r_seq          <= w_seq_next;
      r_init_done    <= w_init_done_d;
      r_pause        <= w_pause_d;
      r_pause_next   <= w_pause_next_d;
      r_header_valid <= w_header_valid_d;
    end
  end

  assign o_init_done     = r_init_done;
  assign o_phase         = r_phase;
  assign o_tx_pause      = r_pause;
  assign o_tx_pause_next = r_pause_next;
  assign o_gt_txsequence = r_seq;
  assign o_header_valid  = r_header_valid;
  assign o_state         = r_state;

endmodule
